// File: rtl/serial_port_bridge.sv
// Buffered serial bridge between the processor serial interface and an external endpoint.
// TX and RX FIFOs with an optional LF -> CR,LF expansion on transmit and sticky overflow flags.
module serial_port_bridge #(
    parameter int DATA_WIDTH  = 8,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int CRLF_EXPAND = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       cpu_wr_data,
    input  logic                        cpu_wren,
    output logic                        cpu_tx_ready,
    output logic [DATA_WIDTH-1:0]       cpu_rd_data,
    output logic                        cpu_rx_valid,
    input  logic                        cpu_rden,
    output logic [DATA_WIDTH-1:0]       dev_tx_data,
    output logic                        dev_tx_valid,
    input  logic                        dev_tx_ready,
    input  logic [DATA_WIDTH-1:0]       dev_rx_data,
    input  logic                        dev_rx_valid,
    input  logic                        ovf_clr,
    output logic                        tx_overflow,
    output logic                        rx_overflow,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [DATA_WIDTH-1:0] LF_CHAR = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] CR_CHAR = DATA_WIDTH'(8'h0D);
    localparam logic [TAW:0] TX_PTR_ONE = {{TAW{1'b0}}, 1'b1};
    localparam logic [RAW:0] RX_PTR_ONE = {{RAW{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_NORM = 1'b0,
        S_LF   = 1'b1
    } tx_state_e;

    logic [DATA_WIDTH-1:0] tx_mem_q [TX_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem_q [RX_DEPTH];

    logic [TAW:0]          tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [RAW:0]          rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    tx_state_e             tx_state_q, tx_state_d;
    logic                  tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;

    logic [TAW:0]          tx_level_s;
    logic [RAW:0]          rx_level_s;
    logic                  tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic                  tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic [DATA_WIDTH-1:0] tx_head_s, dev_tx_data_s, cpu_rd_data_s;

    // The extra pointer MSB makes the difference equal DEPTH exactly when full.
    assign tx_level_s = tx_wr_ptr_q - tx_rd_ptr_q;
    assign rx_level_s = rx_wr_ptr_q - rx_rd_ptr_q;
    assign tx_full_s  = tx_level_s[TAW];
    assign rx_full_s  = rx_level_s[RAW];
    assign tx_empty_s = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign rx_empty_s = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign tx_head_s  = tx_mem_q[tx_rd_ptr_q[TAW-1:0]];
    assign tx_push_s  = cpu_wren & ~tx_full_s;
    assign rx_push_s  = dev_rx_valid & ~rx_full_s;
    assign rx_pop_s   = cpu_rden & ~rx_empty_s;

    // Transmit sequencing: an LF head is presented twice (CR, then LF) before it is popped.
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_pop_s      = 1'b0;
        dev_tx_data_s = {DATA_WIDTH{1'b0}};
        case (tx_state_q)
            S_NORM: begin
                if (tx_empty_s) begin
                    dev_tx_data_s = {DATA_WIDTH{1'b0}};
                end else if ((CRLF_EXPAND != 0) && (tx_head_s == LF_CHAR)) begin
                    dev_tx_data_s = CR_CHAR;
                    if (dev_tx_ready) begin
                        tx_state_d = S_LF;
                    end else begin
                        tx_state_d = S_NORM;
                    end
                end else begin
                    dev_tx_data_s = tx_head_s;
                    tx_pop_s      = dev_tx_ready;
                end
            end
            S_LF: begin
                dev_tx_data_s = LF_CHAR;
                if (dev_tx_ready) begin
                    tx_pop_s   = 1'b1;
                    tx_state_d = S_NORM;
                end else begin
                    tx_state_d = S_LF;
                end
            end
            default: begin
                tx_state_d = S_NORM;
            end
        endcase
    end

    // Pointer advance, sticky flags and RX head decode; ovf_clr wins over a same-cycle set.
    always_comb begin
        tx_wr_ptr_d = tx_push_s ? (tx_wr_ptr_q + TX_PTR_ONE) : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop_s  ? (tx_rd_ptr_q + TX_PTR_ONE) : tx_rd_ptr_q;
        rx_wr_ptr_d = rx_push_s ? (rx_wr_ptr_q + RX_PTR_ONE) : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop_s  ? (rx_rd_ptr_q + RX_PTR_ONE) : rx_rd_ptr_q;
        if (ovf_clr) begin
            tx_ovf_d = 1'b0;
            rx_ovf_d = 1'b0;
        end else begin
            tx_ovf_d = tx_ovf_q | (cpu_wren & tx_full_s);
            rx_ovf_d = rx_ovf_q | (dev_rx_valid & rx_full_s);
        end
        if (rx_empty_s) begin
            cpu_rd_data_s = {DATA_WIDTH{1'b0}};
        end else begin
            cpu_rd_data_s = rx_mem_q[rx_rd_ptr_q[RAW-1:0]];
        end
    end

    // Control state: pointers, transmit phase and overflow flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr_q <= {(TAW+1){1'b0}};
            tx_rd_ptr_q <= {(TAW+1){1'b0}};
            rx_wr_ptr_q <= {(RAW+1){1'b0}};
            rx_rd_ptr_q <= {(RAW+1){1'b0}};
            tx_state_q  <= S_NORM;
            tx_ovf_q    <= 1'b0;
            rx_ovf_q    <= 1'b0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            tx_state_q  <= tx_state_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_ovf_q    <= rx_ovf_d;
        end
    end

    // FIFO storage; contents need no reset because empty pointers mask them.
    always_ff @(posedge clock) begin
        if (tx_push_s) begin
            tx_mem_q[tx_wr_ptr_q[TAW-1:0]] <= cpu_wr_data;
        end
        if (rx_push_s) begin
            rx_mem_q[rx_wr_ptr_q[RAW-1:0]] <= dev_rx_data;
        end
    end

    assign cpu_tx_ready = ~tx_full_s;
    assign cpu_rx_valid = ~rx_empty_s;
    assign cpu_rd_data  = cpu_rd_data_s;
    assign dev_tx_valid = ~tx_empty_s;
    assign dev_tx_data  = dev_tx_data_s;
    assign tx_overflow  = tx_ovf_q;
    assign rx_overflow  = rx_ovf_q;
    assign tx_level     = tx_level_s;
    assign rx_level     = rx_level_s;

endmodule

// File: tb/tb_serial_port_bridge.sv
// Drives two bridges (CRLF expansion off and on) with shared stimulus and compares every
// output each cycle against array-based FIFO reference models.
module tb_serial_port_bridge;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cpu_wr_data = 8'h00, dev_rx_data = 8'h00;
    logic       cpu_wren = 1'b0, cpu_rden = 1'b0, dev_tx_ready = 1'b0;
    logic       dev_rx_valid = 1'b0, ovf_clr = 1'b0;

    logic [1:0]      tx_rdy, tx_vld, rx_vld, tov, rov;
    logic [1:0][7:0] tx_dat, rd_dat;
    logic [1:0][4:0] tx_lvl, rx_lvl;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state: index 1 is the expanding instance.
    logic [7:0] txm [2][16];
    int         txh [2];
    int         txc [2];
    bit         ph  [2];
    bit         tov_m [2];
    logic [7:0] rxm [16];
    int         rxh, rxc;
    bit         rov_m;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        serial_port_bridge #(
            .DATA_WIDTH (8),
            .TX_DEPTH   (16),
            .RX_DEPTH   (16),
            .CRLF_EXPAND(g)
        ) u_dut (
            .clock       (clock),
            .reset       (reset),
            .cpu_wr_data (cpu_wr_data),
            .cpu_wren    (cpu_wren),
            .cpu_tx_ready(tx_rdy[g]),
            .cpu_rd_data (rd_dat[g]),
            .cpu_rx_valid(rx_vld[g]),
            .cpu_rden    (cpu_rden),
            .dev_tx_data (tx_dat[g]),
            .dev_tx_valid(tx_vld[g]),
            .dev_tx_ready(dev_tx_ready),
            .dev_rx_data (dev_rx_data),
            .dev_rx_valid(dev_rx_valid),
            .ovf_clr     (ovf_clr),
            .tx_overflow (tov[g]),
            .rx_overflow (rov[g]),
            .tx_level    (tx_lvl[g]),
            .rx_level    (rx_lvl[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_tx_data(int i);
        logic [7:0] h;
        if (txc[i] == 0) return 8'h00;
        h = txm[i][txh[i]];
        if (i == 1 && h == 8'h0A && !ph[i]) return 8'h0D;
        return h;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            txh[i] = 0; txc[i] = 0; ph[i] = 1'b0; tov_m[i] = 1'b0;
        end
        rxh = 0; rxc = 0; rov_m = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] h;
        int         tail;
        bit         acc;
        if (!reset) begin
            model_reset();
            return;
        end
        acc   = (rxc < 16);
        tail  = (rxh + rxc) % 16;
        rov_m = ovf_clr ? 1'b0 : (rov_m | (dev_rx_valid && !acc));
        if (cpu_rden && rxc > 0) begin
            rxh = (rxh + 1) % 16;
            rxc--;
        end
        if (dev_rx_valid && acc) begin
            rxm[tail] = dev_rx_data;
            rxc++;
        end
        for (int i = 0; i < 2; i++) begin
            acc      = (txc[i] < 16);
            tail     = (txh[i] + txc[i]) % 16;
            tov_m[i] = ovf_clr ? 1'b0 : (tov_m[i] | (cpu_wren && !acc));
            if (txc[i] > 0 && dev_tx_ready) begin
                h = txm[i][txh[i]];
                if (i == 1 && h == 8'h0A && !ph[i]) begin
                    ph[i] = 1'b1;
                end else begin
                    ph[i]  = 1'b0;
                    txh[i] = (txh[i] + 1) % 16;
                    txc[i]--;
                end
            end
            if (cpu_wren && acc) begin
                txm[i][tail] = cpu_wr_data;
                txc[i]++;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("cpu_tx_ready[%0d]", i), 32'(tx_rdy[i]), 32'(txc[i] < 16));
            check_eq($sformatf("dev_tx_valid[%0d]", i), 32'(tx_vld[i]), 32'(txc[i] > 0));
            check_eq($sformatf("dev_tx_data[%0d]", i),  32'(tx_dat[i]), 32'(exp_tx_data(i)));
            check_eq($sformatf("tx_level[%0d]", i),     32'(tx_lvl[i]), txc[i]);
            check_eq($sformatf("tx_overflow[%0d]", i),  32'(tov[i]),    32'(tov_m[i]));
            check_eq($sformatf("cpu_rx_valid[%0d]", i), 32'(rx_vld[i]), 32'(rxc > 0));
            check_eq($sformatf("cpu_rd_data[%0d]", i),  32'(rd_dat[i]), 32'((rxc > 0) ? rxm[rxh] : 8'h00));
            check_eq($sformatf("rx_level[%0d]", i),     32'(rx_lvl[i]), rxc);
            check_eq($sformatf("rx_overflow[%0d]", i),  32'(rov[i]),    32'(rov_m));
        end
    endtask

    task automatic step();
        #2;
        check_all();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic wren, input logic [7:0] wdata, input logic rdy,
                         input logic rxv, input logic [7:0] rxd, input logic rden,
                         input logic clr);
        cpu_wren     = wren;
        cpu_wr_data  = wdata;
        dev_tx_ready = rdy;
        dev_rx_valid = rxv;
        dev_rx_data  = rxd;
        cpu_rden     = rden;
        ovf_clr      = clr;
        step();
    endtask

    initial begin
        int         prob_w, prob_r, prob_rx, prob_rd;
        logic [7:0] d;
        model_reset();
        #1 reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();

        // "Hi\n" with the endpoint always ready
        drive(1'b1, 8'h48, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h69, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h0A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (6) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // LF then 'A', endpoint stalled during the CR beat
        drive(1'b1, 8'h0A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (6) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Fill TX, overflow with 0x5A, clear the flag, then drain
        for (int k = 0; k < 16; k++) drive(1'b1, 8'h60 + 8'(k), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        repeat (20) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // RX: three characters, four pops
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h31, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h32, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // RX full, then push and pop in the same cycle
        for (int k = 0; k < 16; k++) drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h40 + 8'(k), 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0);
        repeat (17) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // Five TX entries pending with the expander in its LF phase, then async reset
        drive(1'b1, 8'h0A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 1; k < 5; k++) drive(1'b1, 8'(k), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        step();
        reset = 1'b1;
        repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Randomised traffic with varying pressure per block
        for (int blk = 0; blk < 12; blk++) begin
            prob_w  = $urandom_range(20, 90);
            prob_r  = $urandom_range(10, 95);
            prob_rx = $urandom_range(20, 90);
            prob_rd = $urandom_range(10, 90);
            repeat (250) begin
                d = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
                drive($urandom_range(0, 99) < prob_w, d,
                      $urandom_range(0, 99) < prob_r,
                      $urandom_range(0, 99) < prob_rx, 8'($urandom),
                      $urandom_range(0, 99) < prob_rd,
                      $urandom_range(0, 99) < 3);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/serial_port_bridge.md
Name: serial_port_bridge

Overview:
- Buffered, parametrised serial port between the processor's serial interface and the external serial endpoint (console monitor or UART).
- TX FIFO decouples processor writes from downstream back-pressure.
- RX FIFO buffers incoming characters for processor reads.
- Optional CR/LF expansion mode on transmit, plus sticky overflow flags and FIFO level outputs for software polling.

Parameters:
DATA_WIDTH, 8, character width in bits; must be >= 8.
TX_DEPTH, 16, TX FIFO entries; power of 2, >= 2.
RX_DEPTH, 16, RX FIFO entries; power of 2, >= 2.
CRLF_EXPAND, 0, when 1 each transmitted LF (0x0A, zero-extended) is sent downstream as CR (0x0D) then LF.

Ports:
clock  in  1  single clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset.
cpu_wr_data  in  DATA_WIDTH  character from processor.
cpu_wren  in  1  active-high push into TX FIFO.
cpu_tx_ready  out  1  TX FIFO not full (drives processor serial_ready_in).
cpu_rd_data  out  DATA_WIDTH  RX FIFO head (first-word fall-through).
cpu_rx_valid  out  1  RX FIFO not empty (drives processor serial_valid_in).
cpu_rden  in  1  active-high pop of RX FIFO.
dev_tx_data  out  DATA_WIDTH  character to endpoint.
dev_tx_valid  out  1  dev_tx_data valid.
dev_tx_ready  in  1  endpoint accepts; transfer = valid & ready.
dev_rx_data  in  DATA_WIDTH  character from endpoint.
dev_rx_valid  in  1  one-cycle push strobe from endpoint (no back-pressure).
ovf_clr  in  1  clears both sticky overflow flags.
tx_overflow  out  1  sticky: cpu_wren seen while cpu_tx_ready=0.
rx_overflow  out  1  sticky: dev_rx_valid seen while RX full.
tx_level  out  $clog2(TX_DEPTH)+1  TX entries held.
rx_level  out  $clog2(RX_DEPTH)+1  RX entries held.

Behaviour:
- Reset (reset=0, asynchronous) empties both FIFOs and sets the TX FSM to S_NORM.
- Output values during and after reset:
  - cpu_tx_ready=1
  - cpu_rx_valid=0, dev_tx_valid=0
  - cpu_rd_data=0, dev_tx_data=0
  - tx_level=0, rx_level=0
  - both overflow flags 0
- Reset asserted mid-transfer discards all buffered data and any pending CR/LF phase.
- cpu_tx_ready = (tx_level < TX_DEPTH), decoded from registered state, so it does not depend on the same-cycle pop.
  - Push when cpu_tx_ready=0: data dropped, tx_overflow set, even if a pop occurs in the same cycle.
- TX latency: a character pushed at edge N appears on dev_tx_valid/dev_tx_data after edge N (visible in cycle N+1) when the FIFO was empty.
- Ordering: strict FIFO. dev_tx_data is held stable while dev_tx_valid=1 and dev_tx_ready=0.
- TX FSM with states S_NORM and S_LF:
  - S_NORM, head != LF or CRLF_EXPAND=0: present head. On transfer, pop and stay in S_NORM.
  - S_NORM, head == LF and CRLF_EXPAND=1: present 0x0D, no pop. On transfer, go to S_LF.
  - S_LF: present 0x0A. On transfer, pop and go to S_NORM.
  - tx_level counts FIFO entries, not downstream beats.
- Simultaneous TX push and pop when not full: both occur and tx_level is unchanged.
- RX push is accepted iff rx_level < RX_DEPTH at the start of the cycle.
  - Otherwise the data is dropped and rx_overflow is set, even if cpu_rden pops in the same cycle.
- RX pop: cpu_rden with cpu_rx_valid=0 is ignored (no underflow, no flag).
- RX latency: a push at edge N gives cpu_rx_valid=1 with cpu_rd_data = that character in cycle N+1.
- Simultaneous RX push (not full) and pop (not empty): both occur.
- Pointers wrap modulo depth; an extra MSB distinguishes full from empty.
- ovf_clr has priority over a same-cycle set: the flag reads 0 after that edge.

Test Plan:
- Reset, then push "Hi\n" (0x48,0x69,0x0A) with dev_tx_ready=1 and CRLF_EXPAND=0 -> dev_tx_data sequence 0x48,0x69,0x0A, first valid one cycle after first push; tx_level returns to 0.
- CRLF_EXPAND=1, push 0x0A then 0x41, dev_tx_ready=1 -> downstream beats 0x0D,0x0A,0x41. With dev_tx_ready low for 3 cycles during the 0x0D beat -> data held at 0x0D, no pop, tx_level stays 2.
- dev_tx_ready=0, push 16 characters (TX_DEPTH=16) -> cpu_tx_ready=0 and tx_level=16; 17th push (0x5A) -> tx_overflow=1 and 0x5A is never transmitted; ovf_clr -> tx_overflow=0.
- Push 0x31,0x32,0x33 via dev_rx_valid -> cpu_rx_valid=1 with cpu_rd_data=0x31; three cpu_rden pops return 0x31,0x32,0x33, then cpu_rx_valid=0; a 4th cpu_rden leaves rx_level=0.
- Fill RX to 16, then assert dev_rx_valid and cpu_rden in the same cycle -> rx_overflow=1, rx_level=15, and the popped entry is the oldest.
- Assert reset low with 5 TX entries pending and the FSM in S_LF -> all outputs at reset values immediately (asynchronous); after release, dev_tx_valid=0 until the next push.
